// File: rtl/vc_buffer_pkg.sv
// Shared sizing for the per-VC flit buffers, so allocator and credit logic
// derive VC select and occupancy widths the same way as the buffer itself.
package vc_buffer_pkg;

    localparam int unsigned FLIT_W_DEF = 8;
    localparam int unsigned DEPTH_DEF  = 8;
    localparam int unsigned NUM_VC_DEF = 2;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r++;
        end
        return r;
    endfunction

    // VC select field is at least one bit wide even for a single VC.
    function automatic int unsigned vc_width(input int unsigned num_vc);
        return (clog2(num_vc) < 1) ? 1 : clog2(num_vc);
    endfunction

    // Occupancy must be able to hold the value DEPTH itself.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return clog2(depth + 1);
    endfunction

endpackage

// File: rtl/flit_fifo.sv
// Single-VC circular FIFO: storage, read/write pointers, occupancy count and
// registered full/empty flags. A write to a full FIFO is accepted when the
// same cycle pops it; a pop of an empty FIFO is ignored (no bypass).
module flit_fifo
    import vc_buffer_pkg::*;
#(
    parameter int unsigned  FLIT_W = FLIT_W_DEF,
    parameter int unsigned  DEPTH  = DEPTH_DEF,
    localparam int unsigned CNT_W  = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_i,
    input  logic              read_i,
    input  logic [FLIT_W-1:0] data_i,
    output logic              wr_acc_o,
    output logic              rd_acc_o,
    output logic [FLIT_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [CNT_W-1:0]  count_o
);

    localparam int unsigned PTR_W = clog2(DEPTH);

    logic [FLIT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              wr_acc, rd_acc;

    assign rd_acc = read_i & ~empty_q;
    assign wr_acc = write_i & (~full_q | rd_acc);

    // Next-state: pointer advance with explicit wrap (DEPTH need not be 2^n).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage is not reset; a write in the reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o   = mem_q[rd_ptr_q];
    assign full_o   = full_q;
    assign empty_o  = empty_q;
    assign count_o  = count_q;
    assign wr_acc_o = wr_acc;
    assign rd_acc_o = rd_acc;

endmodule

// File: rtl/vc_flit_buffer.sv
// Router input-port flit storage: NUM_VC independent FIFOs behind one shared
// write port, with per-VC pop, head view and occupancy for credit return.
// Define VC_BUFFER_ERR_EN to add sticky per-VC overflow/underflow flags.
module vc_flit_buffer
    import vc_buffer_pkg::*;
#(
    parameter int unsigned  FLIT_W = FLIT_W_DEF,
    parameter int unsigned  DEPTH  = DEPTH_DEF,
    parameter int unsigned  NUM_VC = NUM_VC_DEF,
    localparam int unsigned VC_W   = vc_width(NUM_VC),
    localparam int unsigned CNT_W  = cnt_width(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [FLIT_W-1:0]        data_i,
    input  logic                     write_i,
    input  logic [VC_W-1:0]          wr_vc_i,
    input  logic [NUM_VC-1:0]        read_i,
    output logic [NUM_VC*FLIT_W-1:0] data_o,
    output logic [NUM_VC-1:0]        full_o,
    output logic [NUM_VC-1:0]        empty_o,
    output logic [NUM_VC*CNT_W-1:0]  count_o,
`ifdef VC_BUFFER_ERR_EN
    output logic [NUM_VC-1:0]        overflow_o,
    output logic [NUM_VC-1:0]        underflow_o,
`endif
    output logic                     wr_ack_o
);

    logic [NUM_VC-1:0] wr_req;
    logic [NUM_VC-1:0] wr_acc;
    logic [NUM_VC-1:0] rd_acc;

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        // Out-of-range wr_vc_i matches no VC, so the write is dropped.
        assign wr_req[v] = write_i & (wr_vc_i == VC_W'(v));

        flit_fifo #(
            .FLIT_W (FLIT_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .write_i  (wr_req[v]),
            .read_i   (read_i[v]),
            .data_i   (data_i),
            .wr_acc_o (wr_acc[v]),
            .rd_acc_o (rd_acc[v]),
            .data_o   (data_o[v*FLIT_W +: FLIT_W]),
            .full_o   (full_o[v]),
            .empty_o  (empty_o[v]),
            .count_o  (count_o[v*CNT_W +: CNT_W])
        );
    end

    assign wr_ack_o = |wr_acc;

`ifdef VC_BUFFER_ERR_EN
    logic [NUM_VC-1:0] overflow_q;
    logic [NUM_VC-1:0] underflow_q;

    // Sticky error flags: rejected write / pop of an empty VC, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= '0;
            underflow_q <= '0;
        end else begin
            overflow_q  <= overflow_q | (wr_req & ~wr_acc);
            underflow_q <= underflow_q | (read_i & empty_o);
        end
    end

    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;
`endif

endmodule

// File: tb/tb_vc_flit_buffer.sv
// Randomized plus directed bench for vc_flit_buffer. Two instances share the
// stimulus: DEPTH=4 and DEPTH=3 (non-power-of-two wrap), both with NUM_VC=2.
// Expected behaviour comes from per-VC queues. Honours VC_BUFFER_ERR_EN.
module tb_vc_flit_buffer;

    localparam int DA = 4;
    localparam int DB = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data_i;
    logic        write_i;
    logic        wr_vc_i;
    logic [1:0]  read_i;

    logic [15:0] data_a, data_b;
    logic [1:0]  full_a, full_b, empty_a, empty_b;
    logic [5:0]  cnt_a;
    logic [3:0]  cnt_b;
    logic        ack_a, ack_b;
`ifdef VC_BUFFER_ERR_EN
    logic [1:0]  ovf_a, ovf_b, unf_a, unf_b;
`endif

    always #5 clk = ~clk;

    vc_flit_buffer #(.FLIT_W(8), .DEPTH(DA), .NUM_VC(2)) u_dut_a (
        .clk         (clk),
        .rst         (rst),
        .data_i      (data_i),
        .write_i     (write_i),
        .wr_vc_i     (wr_vc_i),
        .read_i      (read_i),
        .data_o      (data_a),
        .full_o      (full_a),
        .empty_o     (empty_a),
        .count_o     (cnt_a),
`ifdef VC_BUFFER_ERR_EN
        .overflow_o  (ovf_a),
        .underflow_o (unf_a),
`endif
        .wr_ack_o    (ack_a)
    );

    vc_flit_buffer #(.FLIT_W(8), .DEPTH(DB), .NUM_VC(2)) u_dut_b (
        .clk         (clk),
        .rst         (rst),
        .data_i      (data_i),
        .write_i     (write_i),
        .wr_vc_i     (wr_vc_i),
        .read_i      (read_i),
        .data_o      (data_b),
        .full_o      (full_b),
        .empty_o     (empty_b),
        .count_o     (cnt_b),
`ifdef VC_BUFFER_ERR_EN
        .overflow_o  (ovf_b),
        .underflow_o (unf_b),
`endif
        .wr_ack_o    (ack_b)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Reference: one queue per (instance, VC); index = inst*2 + vc.
    logic [7:0] q [4][$];
    int         dep [2] = '{DA, DB};
    bit         ovf [4];
    bit         unf [4];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit rd_ok(int k, int v);
        return read_i[v] && (q[k*2+v].size() > 0);
    endfunction

    function automatic bit wr_ok(int k, int v);
        return write_i && (int'(wr_vc_i) == v) &&
               ((q[k*2+v].size() < dep[k]) || rd_ok(k, v));
    endfunction

    task automatic check_state();
        for (int k = 0; k < 2; k++) begin
            for (int v = 0; v < 2; v++) begin
                int         idx;
                int         sz;
                logic [7:0] head;
                logic       f, e;
                logic [2:0] c;
                idx = k*2 + v;
                sz  = q[idx].size();
                if (k == 0) begin
                    head = data_a[v*8 +: 8];
                    f    = full_a[v];
                    e    = empty_a[v];
                    c    = cnt_a[v*3 +: 3];
                end else begin
                    head = data_b[v*8 +: 8];
                    f    = full_b[v];
                    e    = empty_b[v];
                    c    = {1'b0, cnt_b[v*2 +: 2]};
                end
                check_eq($sformatf("count[%0d][%0d]", k, v), 32'(c), 32'(sz));
                check_eq($sformatf("full[%0d][%0d]", k, v), 32'(f), 32'(sz == dep[k]));
                check_eq($sformatf("empty[%0d][%0d]", k, v), 32'(e), 32'(sz == 0));
                if (sz > 0) begin
                    check_eq($sformatf("head[%0d][%0d]", k, v), 32'(head), 32'(q[idx][0]));
                end
`ifdef VC_BUFFER_ERR_EN
                check_eq($sformatf("ovf[%0d][%0d]", k, v),
                         32'((k == 0) ? ovf_a[v] : ovf_b[v]), 32'(ovf[idx]));
                check_eq($sformatf("unf[%0d][%0d]", k, v),
                         32'((k == 0) ? unf_a[v] : unf_b[v]), 32'(unf[idx]));
`endif
            end
        end
    endtask

    // One clock: drive, check wr_ack, clock, update model, check state.
    task automatic step(input bit r, input bit w, input bit vc, input logic [7:0] d,
                        input logic [1:0] rd);
        bit rdv [4];
        bit wrv [4];
        rst     = r;
        write_i = w;
        wr_vc_i = vc;
        data_i  = d;
        read_i  = rd;
        #1;
        if (!r) begin
            check_eq("wr_ack[0]", 32'(ack_a), 32'(wr_ok(0, 0) | wr_ok(0, 1)));
            check_eq("wr_ack[1]", 32'(ack_b), 32'(wr_ok(1, 0) | wr_ok(1, 1)));
        end
        for (int k = 0; k < 2; k++) begin
            for (int v = 0; v < 2; v++) begin
                rdv[k*2+v] = rd_ok(k, v);
                wrv[k*2+v] = wr_ok(k, v);
            end
        end
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            if (r) begin
                q[i].delete();
                ovf[i] = 1'b0;
                unf[i] = 1'b0;
            end else begin
                if (w && (int'(vc) == i % 2) && !wrv[i]) ovf[i] = 1'b1;
                if (rd[i % 2] && q[i].size() == 0) unf[i] = 1'b1;
                if (rdv[i]) void'(q[i].pop_front());
                if (wrv[i]) q[i].push_back(d);
            end
        end
        #1;
        check_state();
    endtask

    initial begin
        logic [7:0] pat [4];
        pat = '{8'h11, 8'h22, 8'h33, 8'h44};

        step(1, 0, 0, 8'h00, 2'b00);
        step(1, 1, 1, 8'hFF, 2'b11);

        // Fill VC0, then one rejected write.
        for (int i = 0; i < 4; i++) step(0, 1, 0, pat[i], 2'b00);
        step(0, 1, 0, 8'h55, 2'b00);
        check_eq("ack_on_full", 32'(ack_a), 32'(0));

        // Drain VC0 and one pop on empty.
        for (int i = 0; i < 5; i++) step(0, 0, 0, 8'h00, 2'b01);

        // Full VC0: write + pop in the same cycle.
        for (int i = 0; i < 4; i++) step(0, 1, 0, pat[i], 2'b00);
        step(0, 1, 0, 8'h66, 2'b01);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 8'h00, 2'b01);

        // Empty VC1: write + pop, pop must be ignored.
        step(0, 1, 1, 8'hA5, 2'b10);
        step(0, 0, 0, 8'h00, 2'b10);

        // Stream 10 flits through VC1 with interleaved pops.
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 1, 8'(8'h30 + i), (i % 2 == 1) ? 2'b10 : 2'b00);
        end
        for (int i = 0; i < 6; i++) step(0, 0, 0, 8'h00, 2'b10);

        // Reset with VC0 holding three flits and a write pending.
        for (int i = 0; i < 3; i++) step(0, 1, 0, pat[i], 2'b00);
        step(1, 1, 0, 8'h77, 2'b01);
        check_eq("empty_after_rst", 32'(empty_a), 32'(2'b11));
        check_eq("count_after_rst", 32'(cnt_a), 32'(0));

        // Random traffic with occasional reset.
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                 1'($urandom), 8'($urandom), 2'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vc_flit_buffer.md
Name: vc_flit_buffer

Overview:
Input-port flit storage for the router. It holds NUM_VC independent circular FIFOs, one per virtual channel, each DEPTH flits deep and FLIT_W bits wide. All VCs share one write port; each VC has its own read port. It feeds the per-VC route/allocation stages and reports per-VC occupancy for credit-based flow control.

Parameters:
FLIT_W, 8, flit width in bits (>=1)
DEPTH, 8, flits per VC (>=2, need not be a power of two)
NUM_VC, 2, number of virtual channels (>=1)
VC_W, derived clog2(NUM_VC) (min 1), width of the VC select field
CNT_W, derived clog2(DEPTH+1), width of the per-VC occupancy count

Ports:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  synchronous active-high reset
data_i  in  FLIT_W  flit to write
write_i  in  1  write request
wr_vc_i  in  VC_W  target VC of the write
read_i  in  NUM_VC  per-VC read (pop) request, bit v selects VC v
data_o  out  NUM_VC*FLIT_W  head flit per VC, VC v at bits [v*FLIT_W +: FLIT_W]
full_o  out  NUM_VC  per-VC full flag, registered
empty_o  out  NUM_VC  per-VC empty flag, registered
count_o  out  NUM_VC*CNT_W  per-VC occupancy, registered
wr_ack_o  out  1  combinational, high when the current write is accepted

Behaviour:
- Reset (rst=1 at clk edge, synchronous): for all VCs, rd_ptr=0, wr_ptr=0, count=0, empty_o=1, full_o=0. Storage array is not reset.
  - data_o is don't-care while empty_o[v]=1.
  - Reset mid-operation discards all stored flits. A write or read in the reset cycle has no effect.
- Per VC v, in each cycle:
  - rd_acc[v] = read_i[v] & ~empty_o[v]
  - wr_acc[v] = write_i & (wr_vc_i==v) & (~full_o[v] | rd_acc[v]); a write to a full VC is accepted when the same VC is popped in the same cycle.
  - wr_ack_o = OR of wr_acc; wr_vc_i >= NUM_VC gives wr_ack_o=0 and no write.
- On wr_acc[v]: mem[v][wr_ptr]<=data_i; wr_ptr advances, wrapping DEPTH-1 -> 0.
- On rd_acc[v]: rd_ptr advances with the same wrap rule.
- count'=count+wr_acc-rd_acc. Then full_o'=(count'==DEPTH) and empty_o'=(count'==0).
  - Simultaneous accepted read+write leaves count and both flags unchanged.
- Read on an empty VC is ignored, including when a write to that VC arrives in the same cycle. There is no bypass: the written flit first appears on data_o the next cycle.
- data_o[v]=mem[v][rd_ptr[v]], combinational from registered state (zero-latency head view). The head changes the cycle after a pop.
- VCs are fully independent: activity on one VC never changes another VC's pointers, flags or count.

Optional Feature:
Macro VC_BUFFER_ERR_EN.
- Defined: adds outputs overflow_o[NUM_VC] and underflow_o[NUM_VC], sticky until rst.
  - overflow_o[v] sets when write_i & wr_vc_i==v & ~wr_acc[v].
  - underflow_o[v] sets when read_i[v] & empty_o[v].
  - Both are registered and visible the cycle after the offending request.
- Undefined: these ports and their logic do not exist; illegal requests are silently dropped as described above.

Decomposition:
- Shared package vc_buffer_pkg: clog2 function, FLIT_W/DEPTH/NUM_VC defaults, and CNT_W/VC_W derivation so that allocator and credit logic size identically.
- One sub-module, flit_fifo (single-VC circular FIFO: pointers, count, flags, storage), instantiated NUM_VC times in a generate loop.
- The top level holds write decode, wr_ack_o, output packing and the optional error flags.

Test Plan (FLIT_W=8, DEPTH=4, NUM_VC=2 unless stated):
- Reset, then write 0x11,0x22,0x33,0x44 to VC0 -> count_o[0] goes 1..4, full_o[0]=1 after the 4th write. A 5th write of 0x55 gives wr_ack_o=0 and contents are unchanged. VC1 stays empty throughout.
- Pop VC0 four times -> data_o[0] shows 0x11,0x22,0x33,0x44 in order, empty_o[0]=1 after the last pop. A further pop leaves pointers unchanged; with VC_BUFFER_ERR_EN, underflow_o[0]=1 the next cycle.
- VC0 full, simultaneous write 0x66 + pop -> wr_ack_o=1, count stays 4, full_o[0] stays 1. The head advances, and 0x66 emerges as the 4th flit read after it.
- VC1 empty, simultaneous write 0xA5 + pop -> pop ignored, count_o[1]=1, data_o[1]=0xA5 the next cycle.
- Streaming of 10 flits through VC1 with interleaved pops -> pointers wrap 3 -> 0, FIFO order is preserved, flags correct every cycle. Repeat with DEPTH=3 to check non-power-of-two wrap.
- Assert rst with VC0 holding 3 flits and a write pending -> next cycle empty_o=2'b11, count_o=0, full_o=0, wr_ack_o has no effect.
